// File: rtl/seg7_capture.sv
// Reader for a multiplexed active-low seven-segment bus: debounces each digit,
// decodes it back to a hex nibble and hands out one frame per full scan.
module seg7_capture #(
    parameter int NDIG          = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [7:0]          nSEG,
    input  logic [NDIG-1:0]     nAN,
    output logic [4*NDIG-1:0]   HEX,
    output logic [NDIG-1:0]     DP,
    output logic [NDIG-1:0]     ERR,
    output logic                VALID,
    input  logic                READY,
    output logic                OVERRUN
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0] CNT_ARM = 8'(STABLE_CYCLES - 2);

    logic [7:0]         s_seg, prev_seg;
    logic [NDIG-1:0]    s_an, prev_an;
    logic [7:0]         cnt;
    logic [NDIG-1:0]    seen;
    logic [4*NDIG-1:0]  work_hex;
    logic [NDIG-1:0]    work_dp, work_err;

    logic               eligible, same, capture, seen_full, load;
    logic [NDIG-1:0]    cap_mask, seen_cap;
    logic [4:0]         dec;
    logic [4*NDIG-1:0]  work_hex_n;
    logic [NDIG-1:0]    work_dp_n, work_err_n;

    // Returns {invalid, nibble}; unknown patterns decode to nibble 0.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b1000000: decode = 5'h00;
            7'b1111001: decode = 5'h01;
            7'b0100100: decode = 5'h02;
            7'b0110000: decode = 5'h03;
            7'b0011001: decode = 5'h04;
            7'b0010010: decode = 5'h05;
            7'b0000010: decode = 5'h06;
            7'b1011000: decode = 5'h07;
            7'b0000000: decode = 5'h08;
            7'b0010000: decode = 5'h09;
            7'b0001000: decode = 5'h0A;
            7'b0000011: decode = 5'h0B;
            7'b1000110: decode = 5'h0C;
            7'b0100001: decode = 5'h0D;
            7'b0000110: decode = 5'h0E;
            7'b0001110: decode = 5'h0F;
            default:    decode = 5'h10;
        endcase
    endfunction

    // Capture fires only on the step into CNT_MAX, so a held digit is taken once.
    always_comb begin
        cap_mask   = ~s_an;
        eligible   = $onehot(cap_mask);
        same       = ({s_an, s_seg} == {prev_an, prev_seg});
        capture    = eligible && same && (cnt == CNT_ARM);
        dec        = decode(s_seg[6:0]);
        work_hex_n = work_hex;
        work_dp_n  = work_dp;
        work_err_n = work_err;
        if (capture) begin
            for (int i = 0; i < NDIG; i++) begin
                if (cap_mask[i]) begin
                    work_hex_n[4*i +: 4] = dec[3:0];
                    work_dp_n[i]         = ~s_seg[7];
                    work_err_n[i]        = dec[4];
                end
            end
        end
        seen_cap  = capture ? (seen | cap_mask) : seen;
        seen_full = &seen;
        load      = seen_full && !VALID;
    end

    // Frame load takes the forwarded working values so a same-edge capture is included.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s_seg    <= 8'hFF;
            s_an     <= '1;
            prev_seg <= 8'hFF;
            prev_an  <= '1;
            cnt      <= '0;
            seen     <= '0;
            work_hex <= '0;
            work_dp  <= '0;
            work_err <= '0;
            HEX      <= '0;
            DP       <= '0;
            ERR      <= '0;
            VALID    <= 1'b0;
            OVERRUN  <= 1'b0;
        end else begin
            s_seg    <= nSEG;
            s_an     <= nAN;
            prev_seg <= s_seg;
            prev_an  <= s_an;
            if (eligible && same) begin
                if (cnt != CNT_MAX)
                    cnt <= cnt + 8'd1;
            end else begin
                cnt <= '0;
            end
            work_hex <= work_hex_n;
            work_dp  <= work_dp_n;
            work_err <= work_err_n;
            OVERRUN  <= capture && VALID && seen_full;
            if (load) begin
                HEX   <= work_hex_n;
                DP    <= work_dp_n;
                ERR   <= work_err_n;
                VALID <= 1'b1;
                seen  <= capture ? cap_mask : '0;
            end else begin
                seen <= seen_cap;
                if (VALID && READY)
                    VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: table of full-scan frames plus
// hand-written sequences for glitches, illegal enables, reset and backpressure.
module tb_seg7_capture;

    localparam int NDIG = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  nSEG;
    logic [3:0]  nAN;
    logic [15:0] HEX;
    logic [3:0]  DP, ERR;
    logic        VALID, READY, OVERRUN;

    int checks = 0;
    int failures = 0;
    int edge_cnt = 0;
    int frame_count = 0;
    int valid_cycles = 0;
    int ovr_count = 0;
    int hold_changes = 0;
    int rise_edge = 0;
    int d3_edge = 0;
    logic        prev_valid = 1'b0;
    logic [15:0] prev_hex = '0;
    logic [3:0]  prev_dp = '0, prev_err = '0;

    typedef struct {
        logic [31:0] segs;
        logic [15:0] hex;
        logic [3:0]  dp;
        logic [3:0]  err;
    } vec_t;
    vec_t vecs[7];

    seg7_capture #(.NDIG(NDIG), .STABLE_CYCLES(4)) dut (
        .CLK(CLK), .RST(RST), .nSEG(nSEG), .nAN(nAN), .HEX(HEX), .DP(DP),
        .ERR(ERR), .VALID(VALID), .READY(READY), .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) edge_cnt <= edge_cnt + 1;

    // Passive monitor on the falling edge: frame arrivals, overrun pulses, held-frame stability.
    always @(negedge CLK) begin
        if (VALID && !prev_valid) begin
            frame_count <= frame_count + 1;
            rise_edge   <= edge_cnt;
        end
        if (VALID) valid_cycles <= valid_cycles + 1;
        if (VALID && prev_valid && (HEX != prev_hex || DP != prev_dp || ERR != prev_err))
            hold_changes <= hold_changes + 1;
        if (OVERRUN) ovr_count <= ovr_count + 1;
        prev_valid <= VALID;
        prev_hex   <= HEX;
        prev_dp    <= DP;
        prev_err   <= ERR;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] an, input logic [7:0] seg, input int n);
        nAN  = an;
        nSEG = seg;
        step(n);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic doReset();
        RST  = 1'b1;
        nAN  = 4'($urandom);
        nSEG = 8'($urandom);
        step(2);
        RST  = 1'b0;
        applyStimulus(4'hF, 8'hFF, 1);
    endtask

    // Each digit held for four cycles, digit 0 first; digit3 start edge is recorded.
    task automatic scan(input logic [31:0] segs, input int first);
        for (int d = first; d < NDIG; d++) begin
            if (d == 3) d3_edge = edge_cnt;
            applyStimulus(~(4'b0001 << d), segs[8*d +: 8], 4);
        end
    endtask

    task automatic waitFrame(input int start, input string name);
        for (int i = 0; i < 20 && frame_count == start; i++) step(1);
        step(1);
        checkOutput(name, 32'(frame_count - start), 32'd1);
    endtask

    initial begin
        int start, vc0, ovr0, hc0;
        vecs[0] = '{32'hB0A4F9C0, 16'h3210, 4'b0000, 4'b0000};
        vecs[1] = '{32'hD8829299, 16'h7654, 4'b0000, 4'b0000};
        vecs[2] = '{32'h83889080, 16'hBA98, 4'b0000, 4'b0000};
        vecs[3] = '{32'h8E86A1C6, 16'hFEDC, 4'b0000, 4'b0000};
        vecs[4] = '{32'hB0FF19C0, 16'h3040, 4'b0010, 4'b0100};
        vecs[5] = '{32'h30247940, 16'h3210, 4'b1111, 4'b0000};
        vecs[6] = '{32'h92C1007F, 16'h5080, 4'b0011, 4'b0101};

        READY = 1'b1;
        doReset();
        checkOutput("reset_hex", 32'(HEX), 32'h0);
        checkOutput("reset_dp", 32'(DP), 32'h0);
        checkOutput("reset_err", 32'(ERR), 32'h0);
        checkOutput("reset_valid", 32'(VALID), 32'h0);
        checkOutput("reset_overrun", 32'(OVERRUN), 32'h0);

        for (int v = 0; v < 7; v++) begin
            start = frame_count;
            vc0   = valid_cycles;
            scan(vecs[v].segs, 0);
            applyStimulus(4'hF, 8'hFF, 1);
            waitFrame(start, $sformatf("vec%0d_frame", v));
            checkOutput($sformatf("vec%0d_hex", v), 32'(prev_hex), 32'(vecs[v].hex));
            checkOutput($sformatf("vec%0d_dp", v), 32'(prev_dp), 32'(vecs[v].dp));
            checkOutput($sformatf("vec%0d_err", v), 32'(prev_err), 32'(vecs[v].err));
            step(3);
            if (v == 0) begin
                checkOutput("valid_latency", 32'(rise_edge - d3_edge), 32'd6);
                checkOutput("valid_one_cycle", 32'(valid_cycles - vc0), 32'd1);
            end
        end

        // Glitch: three-cycle dwell must not register digit 0.
        doReset();
        start = frame_count;
        applyStimulus(4'hE, 8'h92, 3);
        applyStimulus(4'hF, 8'hFF, 3);
        scan(32'hB0A4F900, 1);
        applyStimulus(4'hF, 8'hFF, 6);
        checkOutput("glitch_no_frame", 32'(frame_count - start), 32'd0);
        checkOutput("glitch_valid", 32'(VALID), 32'd0);
        applyStimulus(4'hE, 8'h92, 4);
        applyStimulus(4'hF, 8'hFF, 1);
        waitFrame(start, "glitch_frame");
        checkOutput("glitch_hex", 32'(prev_hex), 32'h3215);

        // Two enables low is never a digit.
        doReset();
        READY = 1'b0;
        start = frame_count;
        applyStimulus(4'hC, 8'hC0, 10);
        scan(32'hB0A4F900, 1);
        applyStimulus(4'hF, 8'hFF, 6);
        checkOutput("illegal_no_frame", 32'(frame_count - start), 32'd0);
        applyStimulus(4'hE, 8'hC0, 4);
        applyStimulus(4'hF, 8'hFF, 1);
        waitFrame(start, "illegal_then_frame");
        checkOutput("pending_valid", 32'(VALID), 32'd1);

        // Reset on the third cycle of a dwell, with a frame pending and three digits seen.
        scan(32'hB0A4F900, 1);
        start = frame_count;
        applyStimulus(4'hE, 8'hC0, 2);
        RST = 1'b1;
        step(1);
        RST = 1'b0;
        checkOutput("midrst_valid", 32'(VALID), 32'd0);
        checkOutput("midrst_hex", 32'(HEX), 32'h0);
        checkOutput("midrst_dp", 32'(DP), 32'h0);
        checkOutput("midrst_err", 32'(ERR), 32'h0);
        checkOutput("midrst_overrun", 32'(OVERRUN), 32'h0);
        step(1);
        READY = 1'b1;
        applyStimulus(4'hF, 8'hFF, 10);
        checkOutput("midrst_no_frame", 32'(frame_count - start), 32'd0);

        // Backpressure: frame 1 held while scan 2 fills the slot and two more captures overrun.
        doReset();
        READY = 1'b0;
        start = frame_count;
        scan(vecs[0].segs, 0);
        applyStimulus(4'hF, 8'hFF, 1);
        waitFrame(start, "bp_frame1");
        ovr0 = ovr_count;
        hc0  = hold_changes;
        scan(vecs[1].segs, 0);
        applyStimulus(4'hE, 8'h88, 4);
        applyStimulus(4'hD, 8'h83, 4);
        applyStimulus(4'hF, 8'hFF, 3);
        checkOutput("bp_overruns", 32'(ovr_count - ovr0), 32'd2);
        checkOutput("bp_hold_changes", 32'(hold_changes - hc0), 32'd0);
        checkOutput("bp_hex_held", 32'(HEX), 32'h3210);
        checkOutput("bp_valid_held", 32'(VALID), 32'd1);
        READY = 1'b1;
        step(1);
        READY = 1'b0;
        checkOutput("bp_valid_drop", 32'(VALID), 32'd0);
        step(1);
        checkOutput("bp_valid_return", 32'(VALID), 32'd1);
        checkOutput("bp_hex2", 32'(HEX), 32'h76BA);
        checkOutput("bp_err2", 32'(ERR), 32'h0);
        READY = 1'b1;
        step(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
